dr32e_data_bus_arb: RTL and testbench
=====================================

# dr32e_data_bus_arb

Two-requester arbiter for the dr32e core's single data-memory port. It shares the bus between the LSU (requester 0) and the debug/system-bus access unit (requester 1). It forwards the winning request to memory with zero added latency and tracks up to two outstanding transactions so that each rvalid/rdata/error is routed back to its issuer. It sits between the LSU/debug unit and the external data interface (gnt/rvalid/bus-error/pmp-error/rdata).

## Interface
- MemECC, 1'b0: ECC enabled on the read-data path. Rdata is passed through unchecked.
- MemDataWidth, MemECC ? 39 : 32: width of every rdata bus.
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- lsu_req_i / dbg_req_i  in  1  request valid. Must stay stable until the matching gnt.
- lsu_we_i / dbg_we_i  in  1  write enable.
- lsu_be_i / dbg_be_i  in  4  byte enables.
- lsu_addr_i / dbg_addr_i  in  32  word-aligned address.
- lsu_wdata_i / dbg_wdata_i  in  32  write data.
- lsu_gnt_o / dbg_gnt_o  out  1  request accepted this cycle.
- lsu_rvalid_o / dbg_rvalid_o  out  1  response valid.
- lsu_rdata_o / dbg_rdata_o  out  MemDataWidth  read data. Both are a copy of data_rdata_i.
- lsu_bus_err_o / dbg_bus_err_o  out  1  bus error. Qualified by the requester's rvalid.
- lsu_pmp_err_o / dbg_pmp_err_o  out  1  PMP error. Qualified by the requester's rvalid.
- data_req_o  out  1  memory request.
- data_we_o  out  1  write enable to memory.
- data_be_o  out  4  byte enables to memory.
- data_addr_o  out  32  address to memory.
- data_wdata_o  out  32  write data to memory.
- data_gnt_i  in  1  memory accepts the request.
- data_rvalid_i  in  1  memory response valid.
- data_rdata_i  in  MemDataWidth  memory read data.
- data_bus_err_i  in  1  memory bus error.
- data_pmp_err_i  in  1  memory PMP error.
- outstanding_o  out  2  count of transactions granted but not yet responded (0..2).
- spurious_rsp_o  out  1  sticky flag: data_rvalid_i was seen with no transaction outstanding.

## Operation
- State registers:
  - owner FIFO: 2 entries × 1 bit, with read pointer, write pointer and 2-bit count.
  - last_id: last requester granted.
  - hold, hold_id: a presented request is waiting for gnt.
  - spurious sticky flag.
- Selection (combinational):
  - If hold=1 and the held requester's req is still 1: sel=hold_id.
  - Otherwise, if only one req is high, that requester wins.
  - Otherwise, if both are high, the requester ≠ last_id wins (round-robin).
- Blocking:
  - When count==2, data_req_o=0 and no gnt is issued.
  - The full check uses the registered count. A pop in the same cycle does not unblock.
- data_req_o = req[sel] & ~full. data_we/be/addr/wdata_o mux from sel. They are don't-care when data_req_o=0.
- Grant routing: gnt[sel] = data_req_o & data_gnt_i. The other gnt is 0.
- hold is set when data_req_o & ~data_gnt_i, with hold_id=sel.
- hold is cleared on a grant, or when the held requester drops req (protocol violation; selection resumes round-robin).
- On a grant:
  - Push sel into the FIFO.
  - last_id ← sel.
- On data_rvalid_i with count>0:
  - Pop the head.
  - Assert rvalid, bus_err and pmp_err only to the head owner.
- On data_rvalid_i with count==0:
  - No pop. No rvalid out.
  - spurious_rsp_o ← 1 until reset.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- Pointers wrap modulo 2.
- Reset values (rst_ni=0):
  - count=0, pointers=0, hold=0, spurious=0.
  - last_id=1, so the LSU wins the first tie.
  - data_req_o and all gnt/rvalid outputs are forced to 0.
  - outstanding_o=0.
- Reset mid-transaction: all FIFO contents are discarded. Responses arriving after release are treated as spurious.

## Timing
- Request path is combinational: req_i → data_req_o → data_gnt_i → *_gnt_o in the same cycle, 0 added latency.
- Response path is combinational: data_rvalid_i → owner rvalid in the same cycle.
- FIFO, count, hold and last_id update on the rising clk_i edge after the event.
- Minimum grant-to-response is 1 cycle, set by memory.
- At most 2 grants may precede the first response. The 3rd request stalls until the cycle after a response.
- A held request has priority over a new request from the other requester for as many cycles as gnt is withheld.

## Test plan
- LSU-only burst:
  - Stimulus: lsu_req with addr 0x100, then 0x104; gnt immediate; rvalid 1 cycle later with rdata 0xDEADBEEF and 0x12345678.
  - Required: lsu_gnt in 2 consecutive cycles; outstanding_o goes 1→2→1→0; lsu_rvalid carries the data in order; dbg_rvalid stays 0.
- Simultaneous requests after reset:
  - Stimulus: both requesters assert req for 3 grants.
  - Required: grants go LSU, dbg, LSU; responses route to the owners in FIFO order.
- Held request:
  - Stimulus: dbg_req alone with gnt=0 for 3 cycles; lsu_req rises in cycle 2.
  - Required: data_addr_o stays at the dbg address; dbg_gnt when gnt=1; LSU granted on the next cycle.
- Full FIFO:
  - Stimulus: 2 grants with no rvalid.
  - Required: data_req_o=0 with lsu_req=1 held.
  - Stimulus: rvalid arrives.
  - Required: data_req_o=1 in the following cycle, not the same cycle.
- Error routing:
  - Stimulus: LSU then dbg granted; 1st response has data_bus_err_i=1, 2nd has data_pmp_err_i=1.
  - Required: lsu_bus_err_o=1 with lsu_rvalid; dbg_pmp_err_o=1 with dbg_rvalid; no cross-talk.
- Spurious response and reset:
  - Stimulus: rvalid with count 0.
  - Required: no rvalid out; spurious_rsp_o=1.
  - Stimulus: assert rst_ni=0 with 1 transaction outstanding.
  - Required: spurious and outstanding clear asynchronously; a post-reset rvalid sets spurious again.

Source files
------------

// File: rtl/dr32e_data_bus_arb.sv
// dr32e_data_bus_arb
//   Shares the single data-memory port between the LSU (requester 0) and the
//   debug/system-bus unit (requester 1). The winning request is forwarded to
//   memory combinationally. A 2-entry owner FIFO remembers who issued each
//   granted transaction so that rvalid/rdata/errors return to the issuer.
//
// Ports
//   clk_i, rst_ni                      core clock, async active-low reset
//   lsu_* / dbg_*  (req/we/be/addr/wdata in; gnt/rvalid/rdata/bus_err/pmp_err out)
//   data_*         memory-side request out, gnt/rvalid/rdata/errors in
//   outstanding_o  granted-but-unanswered transactions (0..2)
//   spurious_rsp_o sticky: rvalid seen with nothing outstanding
module dr32e_data_bus_arb #(
    parameter bit          MemECC       = 1'b0,
    parameter int unsigned MemDataWidth = MemECC ? 39 : 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // LSU requester
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [3:0]              lsu_be_i,
    input  logic [31:0]             lsu_addr_i,
    input  logic [31:0]             lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [MemDataWidth-1:0] lsu_rdata_o,
    output logic                    lsu_bus_err_o,
    output logic                    lsu_pmp_err_o,
    // Debug requester
    input  logic                    dbg_req_i,
    input  logic                    dbg_we_i,
    input  logic [3:0]              dbg_be_i,
    input  logic [31:0]             dbg_addr_i,
    input  logic [31:0]             dbg_wdata_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [MemDataWidth-1:0] dbg_rdata_o,
    output logic                    dbg_bus_err_o,
    output logic                    dbg_pmp_err_o,
    // Memory side
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_addr_o,
    output logic [31:0]             data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [MemDataWidth-1:0] data_rdata_i,
    input  logic                    data_bus_err_i,
    input  logic                    data_pmp_err_i,
    // Status
    output logic [1:0]              outstanding_o,
    output logic                    spurious_rsp_o
);

    logic [1:0] r_fifo;      // owner id per slot
    logic       r_rptr;
    logic       r_wptr;
    logic [1:0] r_count;
    logic       r_last_id;
    logic       r_hold;
    logic       r_hold_id;
    logic       r_spurious;

    logic [1:0] w_req;
    logic       w_sel;
    logic       w_full;
    logic       w_data_req;
    logic       w_grant;
    logic       w_pop;
    logic       w_head;

    assign w_req = {dbg_req_i, lsu_req_i};

    // A stalled request keeps the bus until granted, otherwise round-robin.
    always_comb begin
        w_sel = 1'b0;
        if (r_hold && w_req[r_hold_id]) begin
            w_sel = r_hold_id;
        end else begin
            unique case (w_req)
                2'b01:   w_sel = 1'b0;
                2'b10:   w_sel = 1'b1;
                2'b11:   w_sel = ~r_last_id;
                default: w_sel = 1'b0;
            endcase
        end
    end

    // Registered count only: a pop in this cycle does not free a slot yet.
    assign w_full     = (r_count == 2'd2);
    assign w_data_req = w_req[w_sel] & ~w_full;
    assign w_grant    = w_data_req & data_gnt_i;
    assign w_pop      = data_rvalid_i & (r_count != 2'd0);
    assign w_head     = r_fifo[r_rptr];

    // Request outputs are masked while reset is asserted.
    assign data_req_o   = w_data_req & rst_ni;
    assign data_we_o    = w_sel ? dbg_we_i    : lsu_we_i;
    assign data_be_o    = w_sel ? dbg_be_i    : lsu_be_i;
    assign data_addr_o  = w_sel ? dbg_addr_i  : lsu_addr_i;
    assign data_wdata_o = w_sel ? dbg_wdata_i : lsu_wdata_i;

    assign lsu_gnt_o = w_grant & ~w_sel & rst_ni;
    assign dbg_gnt_o = w_grant &  w_sel & rst_ni;

    assign lsu_rvalid_o  = w_pop & ~w_head;
    assign dbg_rvalid_o  = w_pop &  w_head;
    assign lsu_rdata_o   = data_rdata_i;
    assign dbg_rdata_o   = data_rdata_i;
    assign lsu_bus_err_o = lsu_rvalid_o & data_bus_err_i;
    assign lsu_pmp_err_o = lsu_rvalid_o & data_pmp_err_i;
    assign dbg_bus_err_o = dbg_rvalid_o & data_bus_err_i;
    assign dbg_pmp_err_o = dbg_rvalid_o & data_pmp_err_i;

    assign outstanding_o  = r_count;
    assign spurious_rsp_o = r_spurious;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo     <= 2'b00;
            r_rptr     <= 1'b0;
            r_wptr     <= 1'b0;
            r_count    <= 2'd0;
            r_last_id  <= 1'b1;  // LSU wins the first tie
            r_hold     <= 1'b0;
            r_hold_id  <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            if (w_grant) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ~r_wptr;
                r_last_id      <= w_sel;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_grant) begin
                r_hold <= 1'b0;
            end else if (w_data_req) begin
                r_hold    <= 1'b1;
                r_hold_id <= w_sel;
            end else if (r_hold && !w_req[r_hold_id]) begin
                // Held requester withdrew: fall back to round-robin.
                r_hold <= 1'b0;
            end
            if (data_rvalid_i && (r_count == 2'd0)) begin
                r_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dr32e_data_bus_arb.sv
module tb_dr32e_data_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0, lsu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [3:0]  lsu_be = 4'hF, dbg_be = 4'h3;
    logic [31:0] lsu_addr = 32'h100, dbg_addr = 32'h2000;
    logic [31:0] lsu_wdata = 32'h1111_0000, dbg_wdata = 32'h2222_0000;
    logic        data_gnt = 1'b0, data_rvalid = 1'b0, data_bus_err = 1'b0, data_pmp_err = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    logic        lsu_gnt_o, lsu_rvalid_o, lsu_bus_err_o, lsu_pmp_err_o;
    logic        dbg_gnt_o, dbg_rvalid_o, dbg_bus_err_o, dbg_pmp_err_o;
    logic [31:0] lsu_rdata_o, dbg_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [1:0]  outstanding_o;
    logic        spurious_rsp_o;

    always #5 clk = ~clk;

    dr32e_data_bus_arb dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .lsu_req_i      (lsu_req),
        .lsu_we_i       (lsu_we),
        .lsu_be_i       (lsu_be),
        .lsu_addr_i     (lsu_addr),
        .lsu_wdata_i    (lsu_wdata),
        .lsu_gnt_o      (lsu_gnt_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_bus_err_o  (lsu_bus_err_o),
        .lsu_pmp_err_o  (lsu_pmp_err_o),
        .dbg_req_i      (dbg_req),
        .dbg_we_i       (dbg_we),
        .dbg_be_i       (dbg_be),
        .dbg_addr_i     (dbg_addr),
        .dbg_wdata_i    (dbg_wdata),
        .dbg_gnt_o      (dbg_gnt_o),
        .dbg_rvalid_o   (dbg_rvalid_o),
        .dbg_rdata_o    (dbg_rdata_o),
        .dbg_bus_err_o  (dbg_bus_err_o),
        .dbg_pmp_err_o  (dbg_pmp_err_o),
        .data_req_o     (data_req_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata),
        .data_bus_err_i (data_bus_err),
        .data_pmp_err_i (data_pmp_err),
        .outstanding_o  (outstanding_o),
        .spurious_rsp_o (spurious_rsp_o)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        be;
        logic        pe;
    } rsp_t;

    rsp_t mem_q[$];   // what the memory model still owes
    rsp_t exp_q[$];   // scoreboard: responses each requester should see
    bit   own_q[$];   // reference: owners in grant order
    bit   m_last = 1'b1, m_wait = 1'b0, m_wait_id = 1'b0, m_spur = 1'b0;
    bit   m_lgnt = 1'b0, m_dgnt = 1'b0;
    int   n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        own_q.delete();
        mem_q.delete();
        exp_q.delete();
        m_last = 1'b1;
        m_wait = 1'b0;
        m_spur = 1'b0;
        m_lgnt = 1'b0;
        m_dgnt = 1'b0;
    endfunction

    // Reference model: evaluates arbitration rules per cycle, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin : ref_blk
            bit   req [2];
            bit   sel, ereq, egnt, pop, head;
            int   sz;
            rsp_t e;
            req[0] = lsu_req;
            req[1] = dbg_req;
            sz     = own_q.size();
            if (m_wait && req[m_wait_id]) sel = m_wait_id;
            else if (req[0] && req[1])    sel = !m_last;
            else                          sel = req[1] && !req[0];
            ereq = req[sel] && (sz < 2);
            egnt = ereq && data_gnt;
            chk("data_req", data_req_o, ereq);
            chk("gnt", {lsu_gnt_o, dbg_gnt_o}, {egnt && !sel, egnt && sel});
            chk("outstanding", outstanding_o, sz);
            chk("spurious", spurious_rsp_o, m_spur);
            if (ereq) begin
                chk("fwd_addr", data_addr_o, sel ? dbg_addr : lsu_addr);
                chk("fwd_ctl", {data_we_o, data_be_o, data_wdata_o},
                    sel ? {dbg_we, dbg_be, dbg_wdata} : {lsu_we, lsu_be, lsu_wdata});
            end
            pop  = data_rvalid && (sz > 0);
            head = (sz > 0) ? own_q[0] : 1'b0;
            chk("rvalid_route", {lsu_rvalid_o, dbg_rvalid_o}, {pop && !head, pop && head});
            chk("err_qual", {lsu_bus_err_o, lsu_pmp_err_o, dbg_bus_err_o, dbg_pmp_err_o},
                {pop && !head && data_bus_err, pop && !head && data_pmp_err,
                 pop && head && data_bus_err, pop && head && data_pmp_err});
            if (data_rvalid) begin
                if (sz > 0) void'(own_q.pop_front());
                else        m_spur = 1'b1;
            end
            m_lgnt = egnt && !sel;
            m_dgnt = egnt && sel;
            if (egnt) begin
                own_q.push_back(sel);
                m_last  = sel;
                m_wait  = 1'b0;
                e.id    = sel;
                e.rdata = $urandom;
                e.be    = 1'($urandom_range(0, 1));
                e.pe    = 1'($urandom_range(0, 1));
                mem_q.push_back(e);
                exp_q.push_back(e);
            end else if (ereq) begin
                m_wait    = 1'b1;
                m_wait_id = sel;
            end else if (m_wait && !req[m_wait_id]) begin
                m_wait = 1'b0;
            end
        end
    end

    // Monitor: every response the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (lsu_rvalid_o || dbg_rvalid_o)) begin : mon_blk
            rsp_t e;
            chk("rsp_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_owner", {lsu_rvalid_o, dbg_rvalid_o}, {!e.id, e.id});
                chk("rsp_rdata", e.id ? dbg_rdata_o : lsu_rdata_o, e.rdata);
                chk("rsp_err", {lsu_bus_err_o, lsu_pmp_err_o, dbg_bus_err_o, dbg_pmp_err_o},
                    {!e.id && e.be, !e.id && e.pe, e.id && e.be, e.id && e.pe});
            end
        end
    end

    // Memory response driver; error inputs toggle randomly when rvalid is low.
    task automatic drive_rsp(input bit rv);
        rsp_t e;
        data_rvalid  = rv;
        data_rdata   = $urandom;
        data_bus_err = 1'($urandom_range(0, 1));
        data_pmp_err = 1'($urandom_range(0, 1));
        if (rv && mem_q.size() > 0) begin
            e            = mem_q.pop_front();
            data_rdata   = e.rdata;
            data_bus_err = e.be;
            data_pmp_err = e.pe;
        end
    endtask

    task automatic cyc(input bit lr, input bit dr, input bit g, input bit rv);
        lsu_req  = lr;
        dbg_req  = dr;
        data_gnt = g;
        drive_rsp(rv);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_outstanding"}, outstanding_o, 2'd0);
        chk({tag, "_spurious"}, spurious_rsp_o, 1'b0);
        chk({tag, "_data_req"}, data_req_o, 1'b0);
        chk({tag, "_gnt"}, {lsu_gnt_o, dbg_gnt_o}, 2'b00);
    endtask

    initial begin
        // Reset with a live request and gnt: everything must stay quiet.
        lsu_req  = 1'b1;
        data_gnt = 1'b1;
        #3;
        reset_checks("por");
        lsu_req  = 1'b0;
        data_gnt = 1'b0;
        model_reset();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LSU-only burst
        lsu_addr = 32'h100;
        cyc(1, 0, 1, 0);
        lsu_addr = 32'h104;
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // Simultaneous requests from reset: LSU, dbg, (stall), LSU
        #1 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // Held dbg request beats a later LSU request despite tie-break favouring LSU
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // Spurious response, then async reset with one transaction outstanding
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 0);
        lsu_req  = 1'b1;
        data_gnt = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        reset_checks("async");
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // Randomized traffic honouring the hold-until-gnt protocol
        for (int i = 0; i < 600; i++) begin
            if (!lsu_req || m_lgnt) begin
                lsu_req   = 1'($urandom_range(0, 1));
                lsu_we    = 1'($urandom_range(0, 1));
                lsu_be    = 4'($urandom);
                lsu_addr  = $urandom & 32'hFFFF_FFFC;
                lsu_wdata = $urandom;
            end
            if (!dbg_req || m_dgnt) begin
                dbg_req   = 1'($urandom_range(0, 1));
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_be    = 4'($urandom);
                dbg_addr  = $urandom & 32'hFFFF_FFFC;
                dbg_wdata = $urandom;
            end
            data_gnt = ($urandom_range(0, 3) != 0);
            drive_rsp((mem_q.size() > 0) && ($urandom_range(0, 1) == 1));
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8 && mem_q.size() > 0; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
